// File: rtl/sram_wbuf_ctrl.sv
// sram_wbuf_ctrl: request-side controller in front of a single-port SRAM
// macro (RW0: addr/en/wmode/wdata/rdata, registered-address read).
//
// Independent read and write request streams share the single SRAM port.
// Writes are absorbed into a small FIFO write buffer and drained when the
// port is free. Reads go straight to the port and return data exactly one
// cycle after acceptance.
//
// Build option SRAM_WBUF_BYPASS_EN:
//   defined   - a read that hits a buffered write is accepted at once and
//               answered from the youngest matching buffer entry.
//   undefined - a read that hits a buffered write is stalled until the
//               matching entries have drained to the SRAM.
//
// Handshake: a request transfers on a rising edge where valid and ready are
// both high; ready never depends on valid of the same channel, and the
// read response is a one-cycle pulse with no backpressure.

module sram_wbuf_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 13,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              r_req_valid,
    output logic              r_req_ready,
    input  logic [ADDR_W-1:0] r_req_addr,
    output logic              r_resp_valid,
    output logic [DATA_W-1:0] r_resp_data,
    input  logic              w_req_valid,
    output logic              w_req_ready,
    input  logic [ADDR_W-1:0] w_req_addr,
    input  logic [DATA_W-1:0] w_req_data,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WBUF_DEPTH);

    // Write buffer storage and FIFO bookkeeping
    logic [ADDR_W-1:0] buf_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] buf_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic              full;
    logic              empty;

    // Read address match against the entries held at the start of the cycle
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic [PTR_W-1:0]  scan_idx;

    // Handshakes and port arbitration results
    logic              r_accept;
    logic              w_accept;
    logic              drain;
    logic              read_issue;

    // Read response pipeline
    logic              resp_valid_q;
    logic              resp_sel_q;
    logic [DATA_W-1:0] bypass_data_q;

    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);

    // Scan buffer from oldest to youngest so the last match is the youngest
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        scan_idx = '0;
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (buf_addr[scan_idx] == r_req_addr)) begin
                hit      = 1'b1;
                hit_data = buf_data[scan_idx];
            end
        end
    end

`ifdef SRAM_WBUF_BYPASS_EN
    // Buffered data can answer a matching read, so only a full buffer stalls reads
    assign r_req_ready = !reset && !full;
`else
    // A matching read waits until the older writes have reached the SRAM
    assign r_req_ready = !reset && !full && !hit;
`endif

    assign w_req_ready = !full;

    assign r_accept = r_req_valid && r_req_ready;
    assign w_accept = w_req_valid && w_req_ready && !reset;

    // Port arbitration: full buffer drains first, then reads, then idle drains
    always_comb begin
        drain      = 1'b0;
        read_issue = 1'b0;
        if (!reset) begin
            if (full) begin
                drain = 1'b1;
            end else if (r_accept) begin
                read_issue = 1'b1;
            end else if (!empty) begin
                drain = 1'b1;
            end
        end
    end

    // Drive the SRAM port from the arbitration decision of this cycle
    always_comb begin
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (drain) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = buf_addr[head];
            sram_wdata = buf_data[head];
        end else if (read_issue) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b0;
            sram_addr  = r_req_addr;
        end
    end

    // Capture accepted writes at the tail slot; contents need no reset
    always_ff @(posedge clock) begin
        if (w_accept) begin
            buf_addr[tail] <= w_req_addr;
            buf_data[tail] <= w_req_data;
        end
    end

    // Advance FIFO pointers and occupancy; simultaneous push and pop keep count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (w_accept) begin
                tail <= tail + PTR_ONE;
            end
            if (drain) begin
                head <= head + PTR_ONE;
            end
            case ({w_accept, drain})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Register the response pulse and the data source chosen at accept time
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid_q  <= 1'b0;
            resp_sel_q    <= 1'b0;
            bypass_data_q <= '0;
        end else begin
            resp_valid_q <= r_accept;
            resp_sel_q   <= r_accept && hit;
            if (r_accept && hit) begin
                bypass_data_q <= hit_data;
            end
        end
    end

    assign r_resp_valid = resp_valid_q;
    assign r_resp_data  = resp_sel_q ? bypass_data_q : sram_rdata;

endmodule

// File: tb/tb_sram_wbuf_ctrl.sv
// tb_sram_wbuf_ctrl: bench for sram_wbuf_ctrl with a behavioural SRAM, a
// reference model of the logical memory contents and pending write queue,
// directed scenarios and a randomized phase.

module tb_sram_wbuf_ctrl;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 13;
    localparam int DEPTH  = 4;

`ifdef SRAM_WBUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic              r_req_valid = 1'b0;
    logic              r_req_ready;
    logic [ADDR_W-1:0] r_req_addr  = '0;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              w_req_valid = 1'b0;
    logic              w_req_ready;
    logic [ADDR_W-1:0] w_req_addr  = '0;
    logic [DATA_W-1:0] w_req_data  = '0;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    sram_wbuf_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .WBUF_DEPTH(DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .r_req_valid (r_req_valid),
        .r_req_ready (r_req_ready),
        .r_req_addr  (r_req_addr),
        .r_resp_valid(r_resp_valid),
        .r_resp_data (r_resp_data),
        .w_req_valid (w_req_valid),
        .w_req_ready (w_req_ready),
        .w_req_addr  (w_req_addr),
        .w_req_data  (w_req_data),
        .sram_en     (sram_en),
        .sram_wmode  (sram_wmode),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    // ---------------- behavioural SRAM ----------------
    logic [DATA_W-1:0] sram_mem [256];
    bit                sram_loaded = 1'b0;

    always @(posedge clock) begin
        if (!sram_loaded) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= DATA_W'($urandom_range(0, 8191));
            sram_rdata  <= '0;
            sram_loaded <= 1'b1;
        end else if (sram_en) begin
            if (sram_wmode) sram_mem[sram_addr] <= sram_wdata;
            else            sram_rdata <= sram_mem[sram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] model_mem [256];
    wr_t               pend_q[$];
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each cycle compare port behaviour and responses with the model
    always @(negedge clock) begin
        logic              full;
        logic              match;
        logic              r_acc;
        logic              w_acc;
        logic              drain;
        logic [DATA_W-1:0] e;
        if (reset) begin
            check("rst_sram_en", 32'(sram_en), 32'd0);
            check("rst_resp_valid", 32'(r_resp_valid), 32'd0);
            check("rst_w_ready", 32'(w_req_ready), 32'd1);
            pend_q.delete();
            exp_q.delete();
            for (int i = 0; i < 256; i++) model_mem[i] = sram_mem[i];
        end else begin
            check("resp_valid", 32'(r_resp_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (r_resp_valid) check("resp_data", 32'(r_resp_data), 32'(e));
            end
            full  = (pend_q.size() == DEPTH);
            match = 1'b0;
            foreach (pend_q[i]) if (pend_q[i].a == r_req_addr) match = 1'b1;
            check("w_req_ready", 32'(w_req_ready), 32'(!full));
            check("r_req_ready", 32'(r_req_ready), 32'(!full && (BYP || !match)));
            r_acc = r_req_valid && r_req_ready;
            w_acc = w_req_valid && w_req_ready;
            drain = full || (!r_acc && pend_q.size() > 0);
            check("sram_en", 32'(sram_en), 32'(drain || r_acc));
            if (drain) begin
                check("drain_wmode", 32'(sram_wmode), 32'd1);
                check("drain_addr", 32'(sram_addr), 32'(pend_q[0].a));
                check("drain_wdata", 32'(sram_wdata), 32'(pend_q[0].d));
                void'(pend_q.pop_front());
            end else if (r_acc) begin
                check("read_wmode", 32'(sram_wmode), 32'd0);
                check("read_addr", 32'(sram_addr), 32'(r_req_addr));
                exp_q.push_back(model_mem[r_req_addr]);
            end
            if (w_acc) begin
                pend_q.push_back(wr_t'{a: w_req_addr, d: w_req_data});
                model_mem[w_req_addr] = w_req_data;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int t = 0;
        w_req_valid = 1'b1;
        w_req_addr  = a;
        w_req_data  = d;
        @(negedge clock);
        while (!w_req_ready && t < 64) begin
            t++;
            @(negedge clock);
        end
        check("write_accept_timeout", 32'(w_req_ready), 32'd1);
        @(posedge clock);
        #1;
        w_req_valid = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        int t = 0;
        r_req_valid = 1'b1;
        r_req_addr  = a;
        @(negedge clock);
        while (!r_req_ready && t < 64) begin
            t++;
            @(negedge clock);
        end
        check("read_accept_timeout", 32'(r_req_ready), 32'd1);
        @(posedge clock);
        #1;
        r_req_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit racc;
        bit wacc;
        int rp;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);

        // single write drains on an idle port, then read it back
        do_write(8'hA5, 13'h1234);
        idle(3);
        do_read(8'hA5);
        idle(2);

        // continuous reads fill the buffer until a forced drain
        fork
            begin
                for (int i = 0; i < 8; i++) do_read(8'h10);
            end
            begin
                for (int i = 0; i < 5; i++) do_write(8'(8'h20 + i), 13'(13'h0A00 + i));
            end
        join
        idle(8);
        for (int i = 0; i < 5; i++) do_read(8'(8'h20 + i));
        idle(2);

        // two buffered writes to one address, then a read of it
        fork
            begin
                do_read(8'h50);
                do_read(8'h50);
                do_read(8'h33);
            end
            begin
                do_write(8'h33, 13'h0111);
                do_write(8'h33, 13'h0222);
            end
        join
        idle(6);

        // same-cycle read and write of one address sees the old value
        do_write(8'h44, 13'h0007);
        idle(3);
        fork
            do_read(8'h44);
            do_write(8'h44, 13'h1FFF);
        join
        do_read(8'h44);
        idle(4);

        // reset while the buffer is draining
        fork
            begin
                for (int i = 0; i < 4; i++) do_read(8'h80);
            end
            begin
                for (int i = 0; i < 4; i++) do_write(8'(8'h60 + i), 13'(13'h0C00 + i));
            end
        join
        idle(1);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) do_read(8'(8'h60 + i));
        idle(2);

        // pointer wrap over ten writes, then read all back
        for (int i = 0; i < 10; i++) do_write(8'(i), 13'(13'h100 + i));
        idle(4);
        for (int i = 0; i < 10; i++) do_read(8'(i));
        idle(2);

        // randomized traffic on a small address pool, valid held until accepted
        for (int c = 0; c < 1500; c++) begin
            rp = (c < 750) ? 50 : 90;
            @(negedge clock);
            racc = r_req_valid && r_req_ready;
            wacc = w_req_valid && w_req_ready;
            @(posedge clock);
            #1;
            if (!r_req_valid || racc) begin
                r_req_valid = ($urandom_range(0, 99) < rp);
                r_req_addr  = 8'(8'hC0 + $urandom_range(0, 7));
            end
            if (!w_req_valid || wacc) begin
                w_req_valid = ($urandom_range(0, 99) < 60);
                w_req_addr  = 8'(8'hC0 + $urandom_range(0, 7));
                w_req_data  = DATA_W'($urandom_range(0, 8191));
            end
        end
        @(negedge clock);
        @(posedge clock);
        #1;
        r_req_valid = 1'b0;
        w_req_valid = 1'b0;
        idle(10);
        check("final_pending_empty", 32'(pend_q.size()), 32'd0);
        check("final_resp_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
